// File: rtl/writeback_arbiter.sv
// writeback_arbiter: arbitrates the EX_WB writeback port between ALU and multiplier and tracks pending multiplier destinations
module writeback_arbiter #(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8,
  parameter int MAX_WAIT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ALU_Valid,
  input  logic [REG_ADDR_W-1:0]    ALU_Rd,
  input  logic [DATA_W-1:0]        ALU_Result,
  output logic                     ALU_Ready,
  input  logic                     MUL_Valid,
  input  logic [REG_ADDR_W-1:0]    MUL_Rd,
  input  logic [DATA_W-1:0]        MUL_Result,
  output logic                     MUL_Ready,
  input  logic                     Issue_Mul,
  input  logic [REG_ADDR_W-1:0]    Issue_Mul_Rd,
  output logic [2**REG_ADDR_W-1:0] Pending_Mask,
  output logic                     EX_WB_RegWrite,
  output logic [REG_ADDR_W-1:0]    EX_WB_Write_Reg_Num,
  output logic [DATA_W-1:0]        EX_WB_Write_Data
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam logic [2:0] MAX_W = 3'(MAX_WAIT);
  localparam logic [NREG-1:0] ONE = NREG'(1);
  logic [2:0] wait_cnt, wait_nxt;
  logic [NREG-1:0] mask_nxt;
  logic alu_win;
  // MUL has priority unless the ALU has been starved MAX_WAIT cycles
  always_comb begin
    alu_win   = ALU_Valid && (!MUL_Valid || wait_cnt == MAX_W);
    ALU_Ready = rst_n && alu_win;
    MUL_Ready = rst_n && MUL_Valid && !alu_win;
    wait_nxt  = (!ALU_Valid || ALU_Ready) ? 3'd0 : (wait_cnt == MAX_W ? wait_cnt : wait_cnt + 3'd1);
    mask_nxt  = (Pending_Mask & ~(MUL_Ready ? ONE << MUL_Rd : '0)) | (Issue_Mul ? ONE << Issue_Mul_Rd : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt            <= '0;
      Pending_Mask        <= '0;
      EX_WB_RegWrite      <= 1'b0;
      EX_WB_Write_Reg_Num <= '0;
      EX_WB_Write_Data    <= '0;
    end else begin
      wait_cnt       <= wait_nxt;
      Pending_Mask   <= mask_nxt;
      EX_WB_RegWrite <= ALU_Ready || MUL_Ready;
      if (ALU_Ready || MUL_Ready) begin
        EX_WB_Write_Reg_Num <= ALU_Ready ? ALU_Rd : MUL_Rd;
        EX_WB_Write_Data    <= ALU_Ready ? ALU_Result : MUL_Result;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of grant order, one-cycle latency, scoreboard and async reset
module tb_writeback_arbiter;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       ALU_Valid = 0, MUL_Valid = 0, Issue_Mul = 0;
  logic [2:0] ALU_Rd = 0, MUL_Rd = 0, Issue_Mul_Rd = 0;
  logic [7:0] ALU_Result = 0, MUL_Result = 0;
  logic       ALU_Ready, MUL_Ready, EX_WB_RegWrite;
  logic [7:0] Pending_Mask, EX_WB_Write_Data;
  logic [2:0] EX_WB_Write_Reg_Num;
  int n_chk = 0, n_fail = 0;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ALU_Valid(ALU_Valid), .ALU_Rd(ALU_Rd), .ALU_Result(ALU_Result), .ALU_Ready(ALU_Ready),
    .MUL_Valid(MUL_Valid), .MUL_Rd(MUL_Rd), .MUL_Result(MUL_Result), .MUL_Ready(MUL_Ready),
    .Issue_Mul(Issue_Mul), .Issue_Mul_Rd(Issue_Mul_Rd), .Pending_Mask(Pending_Mask),
    .EX_WB_RegWrite(EX_WB_RegWrite), .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
    .EX_WB_Write_Data(EX_WB_Write_Data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input string tag, input logic we, input logic [2:0] num, input logic [7:0] data);
    chk({tag, "_we"}, 32'(EX_WB_RegWrite), 32'(we));
    chk({tag, "_num"}, 32'(EX_WB_Write_Reg_Num), 32'(num));
    chk({tag, "_data"}, 32'(EX_WB_Write_Data), 32'(data));
  endtask

  task automatic rdy(input string tag, input logic a, input logic m);
    chk({tag, "_alu_rdy"}, 32'(ALU_Ready), 32'(a));
    chk({tag, "_mul_rdy"}, 32'(MUL_Ready), 32'(m));
  endtask

  initial begin
    // reset held with a request present: no readiness, all outputs zero
    ALU_Valid = 1; ALU_Rd = 3'd1; ALU_Result = 8'h77;
    #3;
    rdy("rst", 0, 0);
    step();
    wb("rst", 0, 3'd0, 8'h00);
    chk("rst_mask", 32'(Pending_Mask), 32'h0);
    ALU_Valid = 0;
    rst_n = 1;
    step();
    // single ALU write
    ALU_Valid = 1; ALU_Rd = 3'd3; ALU_Result = 8'h5A;
    #1;
    rdy("alu1", 1, 0);
    step();
    ALU_Valid = 0;
    wb("alu1", 1, 3'd3, 8'h5A);
    // idle: write strobe drops, number and data hold
    for (int i = 0; i < 3; i++) begin
      step();
      wb("idle", 0, 3'd3, 8'h5A);
    end
    // contention: MUL, MUL, ALU, MUL
    ALU_Valid = 1; ALU_Rd = 3'd1; ALU_Result = 8'h11;
    MUL_Valid = 1; MUL_Rd = 3'd4; MUL_Result = 8'h44;
    #1;
    rdy("both1", 0, 1);
    step();
    wb("both1", 1, 3'd4, 8'h44);
    MUL_Rd = 3'd6; MUL_Result = 8'h66;
    #1;
    rdy("both2", 0, 1);
    step();
    wb("both2", 1, 3'd6, 8'h66);
    MUL_Rd = 3'd7; MUL_Result = 8'h77;
    #1;
    rdy("both3", 1, 0);
    step();
    wb("both3", 1, 3'd1, 8'h11);
    ALU_Rd = 3'd2; ALU_Result = 8'h22;
    #1;
    rdy("both4", 0, 1);
    step();
    wb("both4", 1, 3'd7, 8'h77);
    MUL_Valid = 0;
    #1;
    rdy("alu_only", 1, 0);
    step();
    ALU_Valid = 0;
    wb("alu_only", 1, 3'd2, 8'h22);
    // scoreboard set then clear on MUL acceptance
    Issue_Mul = 1; Issue_Mul_Rd = 3'd5;
    step();
    Issue_Mul = 0;
    chk("sb_set", 32'(Pending_Mask), 32'h20);
    MUL_Valid = 1; MUL_Rd = 3'd5; MUL_Result = 8'h99;
    #1;
    rdy("sb_mul", 0, 1);
    step();
    MUL_Valid = 0;
    chk("sb_clr", 32'(Pending_Mask), 32'h00);
    wb("sb_mul", 1, 3'd5, 8'h99);
    // WAW: ALU write to a pending register leaves the bit set
    Issue_Mul = 1; Issue_Mul_Rd = 3'd4;
    step();
    Issue_Mul = 0;
    ALU_Valid = 1; ALU_Rd = 3'd4; ALU_Result = 8'hE4;
    step();
    ALU_Valid = 0;
    chk("waw_mask", 32'(Pending_Mask), 32'h10);
    wb("waw", 1, 3'd4, 8'hE4);
    MUL_Valid = 1; MUL_Rd = 3'd4; MUL_Result = 8'h04;
    step();
    MUL_Valid = 0;
    chk("waw_clr", 32'(Pending_Mask), 32'h00);
    // set and clear of the same bit: set wins
    Issue_Mul = 1; Issue_Mul_Rd = 3'd2;
    step();
    chk("sb_set2", 32'(Pending_Mask), 32'h04);
    MUL_Valid = 1; MUL_Rd = 3'd2; MUL_Result = 8'h12;
    step();
    chk("sb_same", 32'(Pending_Mask), 32'h04);
    // set and clear of different bits both apply
    Issue_Mul_Rd = 3'd3; MUL_Rd = 3'd2; MUL_Result = 8'hAB;
    step();
    chk("sb_diff", 32'(Pending_Mask), 32'h08);
    wb("sb_diff", 1, 3'd2, 8'hAB);
    Issue_Mul_Rd = 3'd2; MUL_Rd = 3'd5; MUL_Result = 8'hCD;
    step();
    chk("sb_0c", 32'(Pending_Mask), 32'h0C);
    wb("pre_rst", 1, 3'd5, 8'hCD);
    // asynchronous reset mid-cycle with a transfer in flight
    #2 rst_n = 0;
    #1;
    wb("async_rst", 0, 3'd0, 8'h00);
    chk("async_mask", 32'(Pending_Mask), 32'h00);
    rdy("async_rst", 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
